// File: rtl/hazard_forward_unit.sv
// ---------------------------------------------------------------------------
// hazard_forward_unit
//
// Hazard bookkeeping for a 5-stage RV32I pipeline. The block captures the
// destination and write-back controls of each decoded instruction, shadows
// them through E/M/W, and drives the forwarding selects, stalls and flushes
// back into the datapath. Every decision is combinational from the shadow
// state plus the D-stage inputs, so hazards are resolved in the same cycle.
//
// Optional feature: define HAZARD_PERF_CNT_EN to build the saturating
// stall/flush performance counters. With the macro undefined, stall_cnt and
// flush_cnt are still present as ports but are tied to zero, and no counter
// flops are built.
// ---------------------------------------------------------------------------
module hazard_forward_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] RdD,
  input  logic                  RegWriteD,
  input  logic [1:0]            ResultSrcD,
  input  logic                  PCSrcE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  // Result select encoding used by the decode controller.
  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_IMM = 2'b11
  } result_src_e;

  // ALU operand source select driven into the execute-stage muxes.
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  // Everything the hazard logic needs about the instruction in E.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    result_src_e           result_src;
  } ex_stage_t;

  // Later stages only need to know which register they will write, if any.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
  } wr_ctrl_t;

  ex_stage_t ex_q, ex_d;
  wr_ctrl_t  mem_q, mem_d;
  wr_ctrl_t  wb_q, wb_d;

  logic      lw_stall;
  fwd_sel_e  fwd_a;
  fwd_sel_e  fwd_b;

  // A producer in M is younger than one in W, so M wins. x0 is hard-wired
  // to zero and must never be forwarded even if something "writes" it.
  function automatic fwd_sel_e pick_forward(
    input logic [REG_ADDR_W-1:0] rs_e,
    input wr_ctrl_t              m,
    input wr_ctrl_t              w
  );
    if (m.reg_write && (m.rd != '0) && (m.rd == rs_e)) begin
      return FWD_M;
    end else if (w.reg_write && (w.rd != '0) && (w.rd == rs_e)) begin
      return FWD_W;
    end
    return FWD_RF;
  endfunction

  // Hazard detection: load-use stall, branch flush and forwarding selects.
  always_comb begin
    // NOTE: every signal written here gets a value on every path, starting
    // from a default, so no latch can be inferred.
    lw_stall = 1'b0;
    fwd_a    = FWD_RF;
    fwd_b    = FWD_RF;

    // Loads always write, so result_src alone identifies a pending load.
    if ((ex_q.result_src == RES_MEM) && (ex_q.rd != '0) &&
        ((ex_q.rd == Rs1D) || (ex_q.rd == Rs2D))) begin
      lw_stall = 1'b1;
    end

    fwd_a = pick_forward(ex_q.rs1, mem_q, wb_q);
    fwd_b = pick_forward(ex_q.rs2, mem_q, wb_q);
  end

  // Control outputs: a taken branch overrides a load-use stall because the
  // instruction in D is on the wrong path and is discarded anyway.
  always_comb begin
    StallF    = lw_stall && !PCSrcE;
    StallD    = lw_stall && !PCSrcE;
    FlushD    = PCSrcE;
    FlushE    = lw_stall || PCSrcE;
    ForwardAE = fwd_a;
    ForwardBE = fwd_b;
  end

  // Next shadow state: E takes D (or a bubble), M takes E, W takes M.
  always_comb begin
    ex_d.rs1        = Rs1D;
    ex_d.rs2        = Rs2D;
    ex_d.rd         = RdD;
    ex_d.reg_write  = RegWriteD;
    ex_d.result_src = result_src_e'(ResultSrcD);
    // A bubble has reg_write=0 and result_src=ALU, so it can neither be
    // forwarded from nor cause a load-use stall downstream.
    if (FlushE) begin
      ex_d = '0;
    end

    mem_d.rd        = ex_q.rd;
    mem_d.reg_write = ex_q.reg_write;

    wb_d            = mem_q;
  end

  // Shadow pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state flops use non-blocking assignments so every register
    // samples the pre-edge values of the others, exactly like hardware.
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating counters: hold at all-ones instead of wrapping to zero.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallD && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (FlushE && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

`else

  // Counters not built: ports kept for a stable interface, driven to zero.
  assign stall_cnt = '0;
  assign flush_cnt = '0;

`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// ---------------------------------------------------------------------------
// Testbench for hazard_forward_unit. A table of D-stage vectors with
// hand-derived expected outputs drives the main pipeline scenarios through a
// scoreboard queue; hand-written sequences cover reset, reset during a
// stall, and counter saturation (CNT_W=4).
// ---------------------------------------------------------------------------
module tb_hazard_forward_unit;

  localparam int RW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] Rs1D, Rs2D, RdD;
  logic          RegWriteD;
  logic [1:0]    ResultSrcD;
  logic          PCSrcE;
  logic          StallF, StallD, FlushD, FlushE;
  logic [1:0]    ForwardAE, ForwardBE;
  logic [CW-1:0] stall_cnt, flush_cnt;

  hazard_forward_unit #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .Rs1D      (Rs1D),
    .Rs2D      (Rs2D),
    .RdD       (RdD),
    .RegWriteD (RegWriteD),
    .ResultSrcD(ResultSrcD),
    .PCSrcE    (PCSrcE),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .FlushE    (FlushE),
    .ForwardAE (ForwardAE),
    .ForwardBE (ForwardBE),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       stall;
    logic       flush_d;
    logic       flush_e;
    logic [1:0] fa;
    logic [1:0] fb;
  } exp_t;

  typedef struct {
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic [RW-1:0] rd;
    logic          rw;
    logic [1:0]    rsrc;
    logic          pc;
    exp_t          exp;
  } vec_t;

  vec_t vecs[$];
  exp_t sb_q[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_stalls = 0;
  int exp_flushes = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int rs1, input int rs2, input int rd, input int rw,
                              input int rsrc, input int pc, input int st, input int fd,
                              input int fe, input int fa, input int fb);
    vec_t v;
    v.rs1 = RW'(rs1); v.rs2 = RW'(rs2); v.rd = RW'(rd);
    v.rw = 1'(rw); v.rsrc = 2'(rsrc); v.pc = 1'(pc);
    v.exp.stall = 1'(st); v.exp.flush_d = 1'(fd); v.exp.flush_e = 1'(fe);
    v.exp.fa = 2'(fa); v.exp.fb = 2'(fb);
    return v;
  endfunction

  task automatic drive_d(input int rs1, input int rs2, input int rd, input int rw,
                         input int rsrc, input int pc);
    Rs1D = RW'(rs1); Rs2D = RW'(rs2); RdD = RW'(rd);
    RegWriteD = 1'(rw); ResultSrcD = 2'(rsrc); PCSrcE = 1'(pc);
  endtask

  // Drive one D-stage vector, compare on the falling edge, then clock it in.
  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    Rs1D = v.rs1; Rs2D = v.rs2; RdD = v.rd;
    RegWriteD = v.rw; ResultSrcD = v.rsrc; PCSrcE = v.pc;
    sb_q.push_back(v.exp);
    if (v.exp.stall)   exp_stalls++;
    if (v.exp.flush_e) exp_flushes++;
    @(negedge clk);
    e = sb_q.pop_front();
    check($sformatf("v%0d StallF", idx),    16'(StallF),    16'(e.stall));
    check($sformatf("v%0d StallD", idx),    16'(StallD),    16'(e.stall));
    check($sformatf("v%0d FlushD", idx),    16'(FlushD),    16'(e.flush_d));
    check($sformatf("v%0d FlushE", idx),    16'(FlushE),    16'(e.flush_e));
    check($sformatf("v%0d ForwardAE", idx), 16'(ForwardAE), 16'(e.fa));
    check($sformatf("v%0d ForwardBE", idx), 16'(ForwardBE), 16'(e.fb));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_sat;
    // ------------------------------------------------------------------
    // Vector table: rs1 rs2 rd rw rsrc pc | stall fd fe fa fb
    // ------------------------------------------------------------------
    // ALU RAW, producer in M
    vecs.push_back(mk(1, 2, 5, 1, 0, 0,  0, 0, 0, 0, 0)); // add x5
    vecs.push_back(mk(5, 9, 0, 0, 0, 0,  0, 0, 0, 0, 0)); // use x5
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 2, 0)); // consumer in E: A<-M
    // ALU RAW with one nop gap, producer in W
    vecs.push_back(mk(0, 0, 6, 1, 0, 0,  0, 0, 0, 0, 0)); // add x6
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0)); // nop
    vecs.push_back(mk(6, 6, 0, 0, 0, 0,  0, 0, 0, 0, 0)); // use x6 twice
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1)); // A,B <- W
    // both M and W write x5: M wins
    vecs.push_back(mk(0, 0, 5, 1, 0, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 5, 1, 0, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 5, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    // non-writing producer never forwards
    vecs.push_back(mk(0, 0, 8, 0, 0, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(8, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    // load-use on Rs2D: one-cycle stall, then B <- W
    vecs.push_back(mk(1, 0, 6, 1, 1, 0,  0, 0, 0, 0, 0)); // lw x6
    vecs.push_back(mk(3, 6, 7, 1, 0, 0,  1, 0, 1, 0, 0)); // stall
    vecs.push_back(mk(3, 6, 7, 1, 0, 0,  0, 0, 0, 0, 0)); // held, released
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    // taken branch: wrong-path add x9 becomes a bubble
    vecs.push_back(mk(0, 0, 9, 1, 0, 1,  0, 1, 1, 0, 0));
    vecs.push_back(mk(9, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0)); // no forward of x9
    // branch together with load-use: branch wins
    vecs.push_back(mk(0, 0, 4, 1, 1, 0,  0, 0, 0, 0, 0)); // lw x4
    vecs.push_back(mk(4, 0, 5, 1, 0, 1,  0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    // x0: load to x0 and write to x0 never stall or forward
    vecs.push_back(mk(0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    // load-use on Rs1D, then A <- W
    vecs.push_back(mk(0, 0, 3, 1, 1, 0,  0, 0, 0, 0, 0)); // lw x3
    vecs.push_back(mk(3, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0));
    vecs.push_back(mk(3, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));

    // ------------------------------------------------------------------
    // Reset: random D inputs, PCSrcE=0 -> all outputs 0
    // ------------------------------------------------------------------
    rst = 1'b1;
    drive_d(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive_d(int'($urandom_range(31)), int'($urandom_range(31)), int'($urandom_range(31)),
              int'($urandom_range(1)), int'($urandom_range(3)), 0);
      @(negedge clk);
      check($sformatf("rst%0d StallF", i),    16'(StallF),    16'h0);
      check($sformatf("rst%0d StallD", i),    16'(StallD),    16'h0);
      check($sformatf("rst%0d FlushD", i),    16'(FlushD),    16'h0);
      check($sformatf("rst%0d FlushE", i),    16'(FlushE),    16'h0);
      check($sformatf("rst%0d ForwardAE", i), 16'(ForwardAE), 16'h0);
      check($sformatf("rst%0d ForwardBE", i), 16'(ForwardBE), 16'h0);
      check($sformatf("rst%0d stall_cnt", i), 16'(stall_cnt), 16'h0);
      check($sformatf("rst%0d flush_cnt", i), 16'(flush_cnt), 16'h0);
      @(posedge clk);
    end
    // PCSrcE still passes straight through to the flushes during reset
    PCSrcE = 1'b1;
    #1;
    check("rst FlushD=PCSrcE", 16'(FlushD), 16'h1);
    check("rst FlushE=PCSrcE", 16'(FlushE), 16'h1);
    check("rst StallD w/ PCSrcE", 16'(StallD), 16'h0);
    PCSrcE = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ------------------------------------------------------------------
    // Table-driven run
    // ------------------------------------------------------------------
    foreach (vecs[i]) run_vec(i, vecs[i]);
    check("scoreboard drained", 16'(sb_q.size()), 16'h0);

`ifdef HAZARD_PERF_CNT_EN
    check("table stall_cnt", 16'(stall_cnt), 16'(exp_stalls));
    check("table flush_cnt", 16'(flush_cnt), 16'(exp_flushes));
`else
    check("table stall_cnt", 16'(stall_cnt), 16'h0);
    check("table flush_cnt", 16'(flush_cnt), 16'h0);
`endif

    // ------------------------------------------------------------------
    // Reset asserted in the middle of a load-use stall
    // ------------------------------------------------------------------
    drive_d(0, 0, 6, 1, 1, 0);                 // lw x6
    @(posedge clk);
    #1;
    drive_d(0, 6, 0, 0, 0, 0);                 // consumer of x6
    #1;
    check("midrst stall before", 16'(StallD), 16'h1);
    rst = 1'b1;
    #1;
    check("midrst StallF", 16'(StallF), 16'h0);
    check("midrst StallD", 16'(StallD), 16'h0);
    check("midrst FlushE", 16'(FlushE), 16'h0);
    check("midrst stall_cnt", 16'(stall_cnt), 16'h0);
    check("midrst flush_cnt", 16'(flush_cnt), 16'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("post-rst StallD", 16'(StallD), 16'h0);
    check("post-rst ForwardBE", 16'(ForwardBE), 16'h0);
    @(posedge clk);
    #1;

    // ------------------------------------------------------------------
    // Saturation: back-to-back dependent loads stall every other cycle,
    // 40 vectors -> 20 stall and 20 flush cycles, counters clamp at 15.
    // ------------------------------------------------------------------
    for (int i = 0; i < 40; i++) begin
      drive_d(6, 0, 6, 1, 1, 0);               // lw x6, 0(x6)
      #2;
      check($sformatf("sat%0d StallD", i), 16'(StallD), 16'(i % 2));
      @(posedge clk);
      #1;
    end
    exp_sat = 15;
`ifdef HAZARD_PERF_CNT_EN
    check("sat stall_cnt", 16'(stall_cnt), 16'(exp_sat));
    check("sat flush_cnt", 16'(flush_cnt), 16'(exp_sat));
`else
    check("sat stall_cnt", 16'(stall_cnt), 16'h0);
    check("sat flush_cnt", 16'(flush_cnt), 16'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Consumer end of the decode controller's control outputs in the 5-stage pipelined RV32I core.
- Captures each decoded instruction's destination and write-back controls.
- Shadows them through E/M/W internally and drives forwarding selects, stall and flush signals back into the datapath.
- The datapath carries only data and register-address pipeline registers; all hazard bookkeeping lives here.

Parameters:
- REG_ADDR_W, 5, register index width.
- CNT_W, 16, width of the performance counters (see Optional Feature).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- Rs1D  input  REG_ADDR_W  source register 1 of the instruction in D.
- Rs2D  input  REG_ADDR_W  source register 2 of the instruction in D.
- RdD  input  REG_ADDR_W  destination register of the instruction in D.
- RegWriteD  input  1  decode controller register-write enable.
- ResultSrcD  input  2  decode controller result select: 00 ALU, 01 memory load, 10 PC+4, 11 immediate.
- PCSrcE  input  1  taken branch or jump resolved in E.
- StallF  output  1  hold PC.
- StallD  output  1  hold the F/D register.
- FlushD  output  1  clear the F/D register.
- FlushE  output  1  clear the D/E register (insert bubble).
- ForwardAE  output  2  ALU operand A select: 00 register file, 10 M-stage result, 01 W-stage result.
- ForwardBE  output  2  ALU operand B select, same encoding as ForwardAE.
- stall_cnt  output  CNT_W  cycles with StallD=1.
- flush_cnt  output  CNT_W  cycles with FlushE=1.

Behaviour:
- Internal shadow registers:
  - E stage: Rs1E, Rs2E, RdE, RegWriteE, ResultSrcE.
  - M stage: RdM, RegWriteM.
  - W stage: RdW, RegWriteW.
- rst=1, asynchronous: all shadow fields and counters clear to 0.
- Consequently, during and right after reset: ForwardAE=ForwardBE=00, StallF=StallD=0, FlushD=PCSrcE, FlushE=PCSrcE.
- Each rising edge with rst=0:
  - M <= E; W <= M.
  - E <= D fields, except when FlushE=1, in which case E <= all zeros (bubble, RegWriteE=0).
- All outputs other than the counters are combinational from the shadow state plus the D inputs; hazard decisions take 0 cycles.
- ForwardAE:
  - 10 if RegWriteM and RdM!=0 and RdM==Rs1E;
  - else 01 if RegWriteW and RdW!=0 and RdW==Rs1E;
  - else 00.
  - M has priority over W.
- ForwardBE: identical rule, using Rs2E.
- Load-use hazard (lwStall): ResultSrcE==01 and RdE!=0 and (RdE==Rs1D or RdE==Rs2D).
  - The RegWriteE term is implied because loads write.
- Default control outputs:
  - StallF = StallD = lwStall and not PCSrcE.
  - FlushD = PCSrcE.
  - FlushE = lwStall or PCSrcE.
- Simultaneous load-use and PCSrcE=1: the branch wins. The D instruction is wrong-path, so StallF=StallD=0 and FlushD=FlushE=1.
- Register x0 never causes a forward or a stall, regardless of the RegWrite value.
- A load-use stall lasts exactly 1 cycle. The bubble pushes the load to W when the consumer reaches E, so the consumer receives ForwardxE=01.
- RdD is unused when RegWriteD=0. E captures it anyway; matching is gated by RegWrite and ResultSrc.
- Counters: increment by 1 on each edge where the respective signal is 1. They saturate at all-ones and do not wrap.
- Reset asserted mid-stall or mid-flush: shadows and counters clear immediately; no stall persists after rst deasserts.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: stall_cnt and flush_cnt counters are implemented as described.
- Undefined: both ports remain present but are tied to constant 0, and no counter flops are synthesized.

Test Plan:
- Reset: hold rst=1 with PCSrcE=0 and random D inputs -> all outputs 0; the shadows are verified by ForwardAE=00 on the first cycle after release.
- ALU RAW: D=add x5 (RdD=5, RegWriteD=1, ResultSrcD=00); next cycle D Rs1D=5; following cycle -> ForwardAE=10. Repeat with one nop gap -> ForwardAE=01. With both M and W writing x5 -> 10.
- Load-use: D=lw x6 (ResultSrcD=01, RdD=6); next cycle Rs2D=6 -> StallF=StallD=FlushE=1 for exactly 1 cycle, then ForwardBE=01, stall_cnt=1, flush_cnt=1.
- Taken branch: PCSrcE=1 for 1 cycle -> FlushD=FlushE=1; next cycle the E shadow is a bubble (a consumer matching the old RdE gets ForwardAE=00).
- Branch during load-use: lwStall condition and PCSrcE=1 together -> StallF=StallD=0, FlushD=FlushE=1.
- x0 and saturation: RdD=0 with RegWriteD=1 and Rs1D=Rs2D=0 -> no forward or stall. With HAZARD_PERF_CNT_EN and CNT_W=4, force 20 stall cycles -> stall_cnt=15. Without the macro -> stall_cnt=0.
